// File: rtl/ber_meter_pkg.sv
// Shared types and defaults for the bit-error-rate meter.
package ber_pkg;

    typedef enum logic {
        RUN = 1'b0,
        LOS = 1'b1
    } ber_state_e;

    localparam int DEF_WINDOW  = 1_000_000;
    localparam int DEF_TIMEOUT = 1_000_000;
    localparam int DEF_CNT_W   = 24;

    // Bits needed to hold a count of 0..n.
    function automatic int pop_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ber_meter_if.sv
// Sample/result bus of the BER meter: the source drives err/val/clr, the meter drives results.
interface ber_meter_if #(
    parameter int N_CH  = 1,
    parameter int CNT_W = ber_pkg::DEF_CNT_W
);
    logic [N_CH-1:0]  err;
    logic             val;
    logic             clr;
    logic [CNT_W-1:0] n_er;
    logic [CNT_W-1:0] n_ok;
    logic             rdy;
    logic             los;
    logic [CNT_W-1:0] n_er_min;
    logic [CNT_W-1:0] n_er_max;

    modport master (
        output err, val, clr,
        input  n_er, n_ok, rdy, los, n_er_min, n_er_max
    );

    modport slave (
        input  err, val, clr,
        output n_er, n_ok, rdy, los, n_er_min, n_er_max
    );
endinterface

// File: rtl/err_popcnt.sv
// Combinational population count of the per-lane error flags.
module err_popcnt
    import ber_pkg::*;
#(
    parameter int N_CH = 1,
    parameter int CW   = pop_w(N_CH)
) (
    input  logic [N_CH-1:0] i_err,
    output logic [CW-1:0]   o_cnt
);

    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            o_cnt = o_cnt + CW'(i_err[i]);
        end
    end

endmodule

// File: rtl/ber_meter.sv
// Windowed bit-error counter with loss-of-signal detection.
// Define BER_MINMAX_EN to track the min/max errored count across windows.
module ber_meter
    import ber_pkg::*;
#(
    parameter int N_CH    = 1,
    parameter int WINDOW  = DEF_WINDOW,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    ber_meter_if.slave   bus
);

    localparam int PW    = pop_w(N_CH);
    localparam int SMP_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int TMO_W = pop_w(TIMEOUT);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(WINDOW * N_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (longint'(WINDOW) * longint'(N_CH) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_cnt_w
        $error("ber_meter: CNT_W cannot hold WINDOW*N_CH");
    end

    ber_state_e       r_state;
    ber_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_n_er;
    logic [CNT_W-1:0] r_n_ok;
    logic [SMP_W-1:0] r_smp;
    logic [TMO_W-1:0] r_tmo;
    logic             r_rdy;
    logic [PW-1:0]    w_pop;
    logic [CNT_W:0]   w_sum_ext;
    logic [CNT_W-1:0] w_sum;
    logic [CNT_W-1:0] w_new_er;
    logic             w_sample;
    logic             w_win_done;
    logic             w_timeout;
    logic             w_report;

    err_popcnt #(.N_CH(N_CH), .CW(PW)) u_popcnt (
        .i_err (bus.err),
        .o_cnt (w_pop)
    );

    assign w_sum_ext = {1'b0, r_acc} + (CNT_W+1)'(w_pop);
    assign w_sum     = w_sum_ext[CNT_W] ? CNT_MAX : w_sum_ext[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // clr outranks val, and any val masks the timeout, so at most one event fires per cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_sample    = 1'b0;
        w_win_done  = 1'b0;
        w_timeout   = 1'b0;
        w_new_er    = r_n_er;
        if (bus.clr) begin
            w_state_nxt = RUN;
        end else if (bus.val) begin
            w_sample    = 1'b1;
            w_state_nxt = RUN;
            if (r_smp == SMP_W'(WINDOW - 1)) begin
                w_win_done = 1'b1;
                w_new_er   = w_sum;
            end
        end else if (r_state == RUN && r_tmo == TMO_W'(TIMEOUT - 1)) begin
            w_timeout   = 1'b1;
            w_state_nxt = LOS;
            w_new_er    = FULL;
        end
    end

    assign w_report = w_win_done | w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_smp  <= '0;
            r_tmo  <= '0;
            r_n_er <= '0;
            r_n_ok <= '0;
            r_rdy  <= 1'b0;
        end else begin
            r_rdy <= w_report;
            if (w_report) begin
                r_n_er <= w_new_er;
                r_n_ok <= FULL - w_new_er;
            end
            if (bus.clr) begin
                r_acc <= '0;
                r_smp <= '0;
                r_tmo <= '0;
            end else if (w_sample) begin
                r_tmo <= '0;
                if (w_win_done) begin
                    r_acc <= '0;
                    r_smp <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_smp <= r_smp + SMP_W'(1);
                end
            end else begin
                if (r_tmo != TMO_W'(TIMEOUT)) begin
                    r_tmo <= r_tmo + TMO_W'(1);
                end
                if (w_timeout) begin
                    r_acc <= '0;
                    r_smp <= '0;
                end
            end
        end
    end

    assign bus.n_er = r_n_er;
    assign bus.n_ok = r_n_ok;
    assign bus.rdy  = r_rdy;
    assign bus.los  = (r_state == LOS);

`ifdef BER_MINMAX_EN
    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_max;

    // LOS reports count as full-error windows for the extremes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min <= CNT_MAX;
            r_max <= '0;
        end else if (bus.clr) begin
            r_min <= CNT_MAX;
            r_max <= '0;
        end else if (w_report) begin
            if (w_new_er < r_min) begin
                r_min <= w_new_er;
            end
            if (w_new_er > r_max) begin
                r_max <= w_new_er;
            end
        end
    end

    assign bus.n_er_min = r_min;
    assign bus.n_er_max = r_max;
`else
    assign bus.n_er_min = '0;
    assign bus.n_er_max = '0;
`endif

endmodule

// File: tb/tb_ber_meter.sv
// Self-checking bench for ber_meter: directed scenarios plus random traffic against a sample-level model.
module tb_ber_meter;

    localparam int N_CH    = 2;
    localparam int WINDOW  = 16;
    localparam int TIMEOUT = 20;
    localparam int CNT_W   = 8;
    localparam int MAXV    = 255;
    localparam int FULLV   = WINDOW * N_CH;

    logic clk;
    logic rst_n;

    ber_meter_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    ber_meter #(
        .N_CH    (N_CH),
        .WINDOW  (WINDOW),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests    = 0;
    int failures = 0;

    // Reference model: error tally and sample count of the open window, idle run length.
    int mErrs;
    int mSamples;
    int mIdle;
    bit mLos;
    bit mRdy;
    int mNer;
    int mNok;
    int mMin;
    int mMax;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int expMin();
`ifdef BER_MINMAX_EN
        return mMin;
`else
        return 0;
`endif
    endfunction

    function automatic int expMax();
`ifdef BER_MINMAX_EN
        return mMax;
`else
        return 0;
`endif
    endfunction

    task automatic modelReset();
        mErrs = 0; mSamples = 0; mIdle = 0; mLos = 0; mRdy = 0;
        mNer = 0; mNok = 0; mMin = MAXV; mMax = 0;
    endtask

    task automatic modelReport(input int ner);
        mRdy = 1;
        mNer = ner;
        mNok = FULLV - ner;
        if (ner < mMin) mMin = ner;
        if (ner > mMax) mMax = ner;
    endtask

    task automatic checkOutput();
        check("rdy",  32'(bus.rdy),      32'(mRdy));
        check("n_er", 32'(bus.n_er),     32'(mNer));
        check("n_ok", 32'(bus.n_ok),     32'(mNok));
        check("los",  32'(bus.los),      32'(mLos));
        check("min",  32'(bus.n_er_min), 32'(expMin()));
        check("max",  32'(bus.n_er_max), 32'(expMax()));
    endtask

    // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
    task automatic applyStimulus(input logic [1:0] e, input bit v, input bit c);
        bus.err = e;
        bus.val = v;
        bus.clr = c;
        @(posedge clk);
        mRdy = 0;
        if (c) begin
            mErrs = 0; mSamples = 0; mIdle = 0; mLos = 0; mMin = MAXV; mMax = 0;
        end else if (v) begin
            mIdle = 0;
            mLos  = 0;
            mErrs += $countones(e);
            mSamples++;
            if (mSamples == WINDOW) begin
                modelReport(mErrs);
                mErrs = 0;
                mSamples = 0;
            end
        end else if (!mLos) begin
            mIdle++;
            if (mIdle == TIMEOUT) begin
                modelReport(FULLV);
                mLos = 1;
                mErrs = 0;
                mSamples = 0;
            end
        end
        #1;
        checkOutput();
    endtask

    int pcts[4] = '{100, 80, 40, 0};

    initial begin
        rst_n   = 1'b0;
        bus.err = '0;
        bus.val = 1'b0;
        bus.clr = 1'b0;
        modelReset();
        #1;
        checkOutput();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Every sample carries exactly one lane error.
        for (int i = 0; i < WINDOW; i++) applyStimulus(2'b01, 1, 0);
        check("r028_rdy", 32'(bus.rdy), 1);
        check("r028_ner", 32'(bus.n_er), 16);
        check("r028_nok", 32'(bus.n_ok), 16);
        applyStimulus(2'b00, 0, 0);

        for (int i = 0; i < WINDOW; i++)
            applyStimulus((i == 3 || i == 9) ? 2'b11 : 2'b00, 1, 0);
        check("r029_ner", 32'(bus.n_er), 4);
        check("r029_nok", 32'(bus.n_ok), 28);
        applyStimulus(2'b00, 1, 0);
        check("r029_single", 32'(bus.rdy), 0);

        // Realign: finish the window opened above.
        for (int i = 1; i < WINDOW; i++) applyStimulus(2'b00, 1, 0);

        for (int i = 0; i < 5; i++) applyStimulus(2'b00, 1, 0);
        for (int i = 0; i < TIMEOUT; i++) applyStimulus(2'b00, 0, 0);
        check("r030_los", 32'(bus.los), 1);
        check("r030_rdy", 32'(bus.rdy), 1);
        check("r030_ner", 32'(bus.n_er), 32);
        check("r030_nok", 32'(bus.n_ok), 0);
        for (int i = 0; i < 3; i++) applyStimulus(2'b00, 0, 0);
        applyStimulus(2'b00, 1, 0);
        check("r030_relock", 32'(bus.los), 0);
        for (int i = 1; i < WINDOW; i++) applyStimulus(2'b00, 1, 0);
        check("r030_ner2", 32'(bus.n_er), 0);
        check("r030_nok2", 32'(bus.n_ok), 32);

        for (int i = 0; i < 8; i++) applyStimulus(2'b11, 1, 0);
        applyStimulus(2'b11, 1, 1);
        for (int i = 0; i < WINDOW; i++) applyStimulus(2'b00, 1, 0);
        check("r031_rdy", 32'(bus.rdy), 1);
        check("r031_ner", 32'(bus.n_er), 0);

        applyStimulus(2'b00, 0, 1);
        for (int i = 0; i < WINDOW; i++) applyStimulus((i < 3) ? 2'b01 : 2'b00, 1, 0);
        for (int i = 0; i < WINDOW; i++)
            applyStimulus((i < 3) ? 2'b11 : ((i == 3) ? 2'b01 : 2'b00), 1, 0);
        for (int i = 0; i < WINDOW; i++) applyStimulus((i == 0) ? 2'b10 : 2'b00, 1, 0);
`ifdef BER_MINMAX_EN
        check("r032_min", 32'(bus.n_er_min), 1);
        check("r032_max", 32'(bus.n_er_max), 7);
        applyStimulus(2'b00, 0, 1);
        check("r032_min_clr", 32'(bus.n_er_min), 255);
        check("r032_max_clr", 32'(bus.n_er_max), 0);
`else
        check("r032_min_off", 32'(bus.n_er_min), 0);
        check("r032_max_off", 32'(bus.n_er_max), 0);
        applyStimulus(2'b00, 0, 1);
`endif

        // Random traffic in phases of varying density; the idle phases force timeouts.
        for (int ph = 0; ph < 12; ph++) begin
            int pct;
            pct = pcts[$urandom_range(0, 3)];
            for (int i = 0; i < 25; i++)
                applyStimulus(2'($urandom_range(0, 3)), ($urandom_range(0, 99) < pct),
                              ($urandom_range(0, 63) == 0));
        end

        applyStimulus(2'b00, 0, 1);
        for (int i = 0; i < 10; i++) applyStimulus(2'($urandom_range(0, 3)), 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        rst_n = 1'b1;
        for (int i = 0; i < WINDOW - 1; i++) applyStimulus(2'b01, 1, 0);
        check("r033_nordy", 32'(bus.rdy), 0);
        applyStimulus(2'b01, 1, 0);
        check("r033_rdy", 32'(bus.rdy), 1);
        check("r033_ner", 32'(bus.n_er), 16);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/ber_meter.md
BER_METER -- requirements
Module: ber_meter

Interface
REQ-001 Parameter N_CH, default 1: lane count; err carries one error flag per lane.
REQ-002 Parameter WINDOW, default 1_000_000: val samples per measurement window.
REQ-003 Parameter TIMEOUT, default 1_000_000: clk cycles without val before loss-of-signal.
REQ-004 Parameter CNT_W, default 24: width of result counters; must hold WINDOW*N_CH, else elaboration error.
REQ-005 Ports: clk in 1, the single clock; rst_n in 1, reset, asynchronous, active-low.
REQ-006 Ports: err in N_CH, per-lane error flags, qualified by val; val in 1, sample strobe.
REQ-007 Ports: clr in 1, synchronous measurement restart.
REQ-008 Ports: n_er out CNT_W, errored-sample count of the last window; n_ok out CNT_W, error-free count of the last window.
REQ-009 Ports: rdy out 1, one-cycle pulse when n_er/n_ok update; los out 1, loss-of-signal flag.
REQ-010 Ports: n_er_min out CNT_W, n_er_max out CNT_W, extreme window counts since reset/clr.

Function
REQ-011 States RUN and LOS; reset state RUN.
REQ-012 Each val cycle adds popcount(err) to accumulator acc, saturating at 2^CNT_W-1, and advances sample counter smp 0..WINDOW-1.
REQ-013 val with smp==WINDOW-1: next cycle n_er=acc+popcount(err), n_ok=WINDOW*N_CH-n_er, rdy=1; acc and smp return to 0.
REQ-014 Latency: final window val to rdy/n_er valid is exactly 1 clk.
REQ-015 Timeout counter tmo: 0 on val, else +1, held at TIMEOUT.
REQ-016 tmo reaching TIMEOUT in RUN: go LOS, los=1, n_er=WINDOW*N_CH, n_ok=0, rdy=1 for one cycle, acc=0, smp=0.
REQ-017 In LOS, no further rdy pulses; n_er/n_ok hold.
REQ-018 First val in LOS: go RUN, los=0 next cycle; that val is sample 0 of a fresh window.
REQ-019 val on a cycle suppresses timeout that cycle; a val and timeout never fire together.
REQ-020 clr priority over val: acc, smp, tmo zeroed, state RUN, los=0, min/max re-armed; the coincident val sample is dropped; n_er/n_ok hold; no rdy.
REQ-021 n_er/n_ok/rdy change only per REQ-013/016.

Reset
REQ-022 rst_n low: n_er=0, n_ok=0, rdy=0, los=0, n_er_min=2^CNT_W-1 (re-armed), n_er_max=0, acc=0, smp=0, tmo=0, state RUN.
REQ-023 Reset mid-window discards the partial window; first post-reset val is sample 0.

Configuration
REQ-024 Macro BER_MINMAX_EN defined: at every rdy, n_er_min=min(n_er_min,new n_er) and n_er_max=max(n_er_max,new n_er), LOS results included; clr re-arms per REQ-022.
REQ-025 BER_MINMAX_EN undefined: n_er_min and n_er_max tied to 0, no tracking logic; all other behaviour identical.

Structure
REQ-026 Package ber_pkg holds the state enum (RUN, LOS) and default constants for WINDOW, TIMEOUT, CNT_W.
REQ-027 Sub-module err_popcnt, parameterised by N_CH, combinationally sums err bits; ber_meter instantiates it once.

Verification (N_CH=2, WINDOW=16, TIMEOUT=20, CNT_W=8 unless noted)
REQ-028 16 consecutive val, err=2'b01 each -> rdy 1 clk after 16th val, n_er=16, n_ok=16.
REQ-029 16 val, err=2'b11 on samples 3 and 9, else 0 -> n_er=4, n_ok=28, rdy single cycle.
REQ-030 5 val, then 20 idle clk -> los=1, rdy pulse, n_er=32, n_ok=0; next val -> los=0, 16 further clean val -> n_er=0, n_ok=32.
REQ-031 8 val with err=2'b11, clr together with 9th val, then 16 clean val -> no rdy before; then n_er=0; clr cycle sample not counted.
REQ-032 BER_MINMAX_EN defined, windows with 3, 7, 1 errors -> n_er_min=1, n_er_max=7; after clr -> min=255, max=0; undefined -> both 0 throughout.
REQ-033 rst_n low 2 clk mid-window (after 10 val), async to clk -> outputs per REQ-022 immediately; 16 val after release yields first rdy.
